control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control FSM for the pratica_2 processor; the producer side of the BusWires interface.
- Fetches a 16-bit instruction from memory using r7 as the PC, then sequences execution.
- Each cycle it generates the one-hot 11-bit bus select consumed by the bus multiplexer, plus the register, ALU, IR, address and memory enables that capture BusWires.

Parameters:
- OPW, 4, opcode field width (ir[15:12]).
- NREG, 8, number of general registers r0..r7; r7 is the PC.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  start/continue execution; sampled in IDLE and in the last state of each instruction.
- ir  in  16  current instruction register contents; op=ir[15:12], rx=ir[11:9], ry=ir[8:6], ir[5:0] ignored.
- g_nz  in  1  G register is non-zero.
- control  out  11  one-hot bus select, declared [0:10]: control[0]=din, control[1+i]=r_i (i=0..7), control[9]=g, control[10]=mem.
- rin  out  8  register write enables; rin[i] loads r_i from BusWires.
- ain  out  1  load ALU A register.
- gin  out  1  load G with A±BusWires.
- addsub  out  1  0=add, 1=sub; valid when gin=1.
- irin  out  1  load IR from BusWires.
- addr_in  out  1  load memory address register.
- pc_incr  out  1  increment r7.
- dout_in  out  1  load memory write-data register.
- w_d  out  1  memory write strobe.
- done  out  1  one-cycle pulse in the last cycle of each instruction.

Behaviour:
- Asynchronous active-low reset: state=IDLE and every output 0, including control=11'b0.
- Single state register. Outputs are combinational decodes of state, ir and g_nz.
- control is exactly one-hot, or all-zero when no bus transfer occurs. It is never multi-hot.
- At most one rin bit is high per cycle.
- States are IDLE, F0, F1, F2, E0, E1, E2. All transitions are on the rising clock edge.
- IDLE: all outputs 0. If run=1, go to F0; otherwise stay in IDLE.
- F0: control[8] (r7) and addr_in; go to F1.
- F1: pc_incr (memory read latency slot); go to F2.
- F2: control[10] (mem) and irin; go to E0.
- Execute states, by opcode:
  - op0 mv rx,ry: E0 drives control[1+ry] and rin[rx]; done.
  - op1 mvi rx,#imm (immediate is the next word): E0 drives control[8], addr_in, pc_incr. E1 waits. E2 drives control[10] and rin[rx]; done.
  - op2 add / op3 sub: E0 drives control[1+rx] and ain. E1 drives control[1+ry], gin, addsub=(op==3). E2 drives control[9] and rin[rx]; done.
  - op4 ld rx,[ry]: E0 drives control[1+ry] and addr_in. E1 waits. E2 drives control[10] and rin[rx]; done.
  - op5 st rx,[ry]: E0 drives control[1+ry] and addr_in. E1 drives control[1+rx], dout_in, w_d; done.
  - op6 mvnz rx,ry: E0 drives control[1+ry] and rin[rx] only if g_nz=1, otherwise control=0 and rin=0; done in either case.
  - op7..op15: treated as nop; E0 asserts done only.
- After the done state: go to F0 if run=1, else IDLE.
- run is ignored in all other states; deasserting run mid-instruction does not abort it.
- rx=7 or ry=7 is legal. Writing r7 redirects the PC for the next fetch.
- In the mvi E0 state, pc_incr and control[8] are asserted in the same cycle. The address register captures the pre-increment PC.
- done is high exactly one cycle per instruction and is never high in IDLE or in F0..F2.
- Reset asserted in any state returns to IDLE immediately. All enables drop in the same cycle, with no partial write strobe.
- Latency per instruction is fetch 3 cycles plus execute: mv/mvnz/nop 1, st 2, mvi/add/sub/ld 3.

Test Plan:
- Reset: hold resetn=0 with run=1 → control=0, rin=0, done=0. Release reset → F0 next edge with control=11'b00000000100 and addr_in=1.
- mv r2,r5 (ir=16'h0540), run=1 → F0..F2 as specified, then E0 with control=11'b00000010000, rin=8'b00000100, done=1. Next cycle is F0.
- add r1,r3 (ir=16'h22C0) → E0 control[2] with ain; E1 control[4] with gin and addsub=0; E2 control[9] with rin=8'b00000010 and done. With sub (ir=16'h32C0), E1 has addsub=1.
- mvnz r0,r1 (ir=16'h6040) → with g_nz=0, E0 has control=0 and rin=0 with done=1. With g_nz=1, E0 has control[2]=1 and rin[0]=1.
- st r4,[r6] (ir=16'h5980) → E0 control[7] with addr_in; E1 control[5] with dout_in, w_d and done. Total 5 cycles from F0.
- Reset mid-operation: assert resetn=0 in E1 of ld → same cycle all outputs 0. After release with run=0, the FSM stays in IDLE.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/execute sequencer driving the BusWires select and capture enables
// Ports:
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   run                   start/continue; sampled in IDLE and in each instruction's done state
//   ir, g_nz              instruction register contents and G-non-zero flag
//   control[0:NREG+2]     one-hot bus select: [0]=din, [1+i]=r_i, [NREG+1]=g, [NREG+2]=mem
//   rin                   register write enables (at most one hot)
//   ain, gin, addsub      ALU A load, G load, add/sub select
//   irin, addr_in         IR load, memory address load
//   pc_incr               r7 increment
//   dout_in, w_d          write-data load, memory write strobe
//   done                  one-cycle pulse in the last cycle of each instruction
module control_unit #(
   parameter int OPW  = 4,
   parameter int NREG = 8
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            run,
   input  logic [15:0]     ir,
   input  logic            g_nz,
   output logic [0:NREG+2] control,
   output logic [NREG-1:0] rin,
   output logic            ain,
   output logic            gin,
   output logic            addsub,
   output logic            irin,
   output logic            addr_in,
   output logic            pc_incr,
   output logic            dout_in,
   output logic            w_d,
   output logic            done
);
   localparam logic [OPW-1:0] OP_MV   = OPW'(0);
   localparam logic [OPW-1:0] OP_MVI  = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
   localparam logic [OPW-1:0] OP_LD   = OPW'(4);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5);
   localparam logic [OPW-1:0] OP_MVNZ = OPW'(6);
   typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_E0, S_E1, S_E2} state_t;
   state_t          state_q, state_d;
   logic [OPW-1:0]  op;
   logic [2:0]      rx, ry;
   logic [NREG-1:0] rx_oh, ry_oh, r_sel;
   logic            sel_g, sel_mem;
   logic [NREG+2:0] sel;
   logic            unused_ir;
   assign op        = ir[15 -: OPW];
   assign rx        = ir[11:9];
   assign ry        = ir[8:6];
   assign unused_ir = ^ir[5:0];
   assign rx_oh     = NREG'(1) << rx;
   assign ry_oh     = NREG'(1) << ry;
   // Bit i of sel maps to control[i]; din is never sourced by this sequencer.
   assign sel       = {sel_mem, sel_g, r_sel, 1'b0};
   for (genvar i = 0; i < NREG + 3; i++) begin : g_ctl
      assign control[i] = sel[i];
   end
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end
   // Every instruction ends in the state that raises done, so done alone decides the return.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = run ? S_F0 : S_IDLE;
         S_F0:    state_d = S_F1;
         S_F1:    state_d = S_F2;
         S_F2:    state_d = S_E0;
         S_E0:    state_d = S_E1;
         S_E1:    state_d = S_E2;
         default: state_d = S_IDLE;
      endcase
      if (done) state_d = run ? S_F0 : S_IDLE;
   end
   always_comb begin
      r_sel   = '0;
      sel_g   = 1'b0;
      sel_mem = 1'b0;
      rin     = '0;
      ain     = 1'b0;
      gin     = 1'b0;
      addsub  = 1'b0;
      irin    = 1'b0;
      addr_in = 1'b0;
      pc_incr = 1'b0;
      dout_in = 1'b0;
      w_d     = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_F0: begin
            r_sel[NREG-1] = 1'b1;
            addr_in       = 1'b1;
         end
         S_F1: pc_incr = 1'b1;
         S_F2: begin
            sel_mem = 1'b1;
            irin    = 1'b1;
         end
         S_E0: case (op)
            OP_MV: begin
               r_sel = ry_oh;
               rin   = rx_oh;
               done  = 1'b1;
            end
            // Address register takes the pre-increment PC while r7 advances past the immediate.
            OP_MVI: begin
               r_sel[NREG-1] = 1'b1;
               addr_in       = 1'b1;
               pc_incr       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               r_sel = rx_oh;
               ain   = 1'b1;
            end
            OP_LD, OP_ST: begin
               r_sel   = ry_oh;
               addr_in = 1'b1;
            end
            OP_MVNZ: begin
               r_sel = g_nz ? ry_oh : '0;
               rin   = g_nz ? rx_oh : '0;
               done  = 1'b1;
            end
            default: done = 1'b1;
         endcase
         S_E1: case (op)
            OP_ADD, OP_SUB: begin
               r_sel  = ry_oh;
               gin    = 1'b1;
               addsub = (op == OP_SUB);
            end
            OP_ST: begin
               r_sel   = rx_oh;
               dout_in = 1'b1;
               w_d     = 1'b1;
               done    = 1'b1;
            end
            default: ;
         endcase
         S_E2: case (op)
            OP_MVI, OP_LD: begin
               sel_mem = 1'b1;
               rin     = rx_oh;
               done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               sel_g = 1'b1;
               rin   = rx_oh;
               done  = 1'b1;
            end
            default: ;
         endcase
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit
module tb_control_unit;
   logic        clock = 1'b0;
   logic        resetn, run, g_nz;
   logic [15:0] ir;
   logic [0:10] control;
   logic [7:0]  rin;
   logic        ain, gin, addsub, irin, addr_in, pc_incr, dout_in, w_d, done;
   localparam logic [8:0] F_NONE = 9'b000000000;
   localparam logic [8:0] F_AIN  = 9'b100000000;
   localparam logic [8:0] F_GIN  = 9'b010000000;
   localparam logic [8:0] F_SUB  = 9'b001000000;
   localparam logic [8:0] F_IR   = 9'b000100000;
   localparam logic [8:0] F_ADDR = 9'b000010000;
   localparam logic [8:0] F_PC   = 9'b000001000;
   localparam logic [8:0] F_DOUT = 9'b000000100;
   localparam logic [8:0] F_WD   = 9'b000000010;
   localparam logic [8:0] F_DONE = 9'b000000001;
   localparam logic [10:0] C_NONE = 11'b00000000000;
   localparam logic [10:0] C_R7   = 11'b00000000100;
   localparam logic [10:0] C_MEM  = 11'b00000000001;
   localparam logic [10:0] C_G    = 11'b00000000010;
   typedef struct {
      string       nm;
      logic [27:0] v;
   } exp_t;
   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   control_unit dut (
      .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_nz(g_nz),
      .control(control), .rin(rin), .ain(ain), .gin(gin), .addsub(addsub),
      .irin(irin), .addr_in(addr_in), .pc_incr(pc_incr), .dout_in(dout_in),
      .w_d(w_d), .done(done)
   );
   always #5 clock = ~clock;
   logic [27:0] act;
   assign act = {control, rin, ain, gin, addsub, irin, addr_in, pc_incr, dout_in, w_d, done};
   always @(negedge clock) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (act === e.v) passed++;
         else $display("FAIL %s: got ctl=%b rin=%b flags=%b, want ctl=%b rin=%b flags=%b",
                       e.nm, act[27:17], act[16:9], act[8:0], e.v[27:17], e.v[16:9], e.v[8:0]);
      end
   end
   task automatic push(input string nm, input logic [10:0] c, input logic [7:0] r, input logic [8:0] f);
      exp_t e;
      e.nm = nm;
      e.v  = {c, r, f};
      sb.push_back(e);
   endtask
   task automatic step(input string nm, input logic [10:0] c, input logic [7:0] r, input logic [8:0] f);
      @(posedge clock);
      #1;
      push(nm, c, r, f);
   endtask
   task automatic fetch(input string nm, input logic [15:0] iv, input logic g);
      @(posedge clock);
      #1;
      ir   = iv;
      g_nz = g;
      push({nm, "_f0"}, C_R7, 8'h00, F_ADDR);
      step({nm, "_f1"}, C_NONE, 8'h00, F_PC);
      step({nm, "_f2"}, C_MEM, 8'h00, F_IR);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end
   initial begin
      resetn = 1'b0;
      run    = 1'b1;
      ir     = 16'h0000;
      g_nz   = 1'b0;
      #2;
      push("reset", C_NONE, 8'h00, F_NONE);
      @(negedge clock);
      #1;
      resetn = 1'b1;
      fetch("mv", 16'h0540, 1'b0);
      step("mv_e0", 11'b00000010000, 8'b00000100, F_DONE);
      fetch("add", 16'h22C0, 1'b0);
      step("add_e0", 11'b00100000000, 8'h00, F_AIN);
      step("add_e1", 11'b00001000000, 8'h00, F_GIN);
      step("add_e2", C_G, 8'b00000010, F_DONE);
      fetch("sub", 16'h32C0, 1'b0);
      step("sub_e0", 11'b00100000000, 8'h00, F_AIN);
      step("sub_e1", 11'b00001000000, 8'h00, F_GIN | F_SUB);
      step("sub_e2", C_G, 8'b00000010, F_DONE);
      fetch("mvnz0", 16'h6040, 1'b0);
      step("mvnz0_e0", C_NONE, 8'h00, F_DONE);
      fetch("mvnz1", 16'h6040, 1'b1);
      step("mvnz1_e0", 11'b00100000000, 8'b00000001, F_DONE);
      fetch("st", 16'h5980, 1'b0);
      step("st_e0", 11'b00000001000, 8'h00, F_ADDR);
      step("st_e1", 11'b00000100000, 8'h00, F_DOUT | F_WD | F_DONE);
      fetch("mvi", 16'h1600, 1'b0);
      step("mvi_e0", C_R7, 8'h00, F_ADDR | F_PC);
      step("mvi_e1", C_NONE, 8'h00, F_NONE);
      step("mvi_e2", C_MEM, 8'b00001000, F_DONE);
      fetch("nopf", 16'hF000, 1'b0);
      step("nopf_e0", C_NONE, 8'h00, F_DONE);
      fetch("nop7", 16'h7000, 1'b0);
      step("nop7_e0", C_NONE, 8'h00, F_DONE);
      run = 1'b0;
      step("idle_after_done", C_NONE, 8'h00, F_NONE);
      step("idle_hold", C_NONE, 8'h00, F_NONE);
      run = 1'b1;
      fetch("ld", 16'h43C0, 1'b0);
      step("ld_e0", C_R7, 8'h00, F_ADDR);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      run    = 1'b0;
      push("ld_e1_reset", C_NONE, 8'h00, F_NONE);
      step("reset_hold", C_NONE, 8'h00, F_NONE);
      @(negedge clock);
      #1;
      resetn = 1'b1;
      step("idle_run0_a", C_NONE, 8'h00, F_NONE);
      step("idle_run0_b", C_NONE, 8'h00, F_NONE);
      run = 1'b1;
      step("restart_f0", C_R7, 8'h00, F_ADDR);
      @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
         total += sb.size();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
